flash_spi_arbiter_pm: RTL and testbench

Arbitrates the shared SPI configuration flash between the DSP (external bus, block #2) and FPGA3 (dedicated req/gnt pins) inside the PM CPLD. It sequences ownership changes through a guarded turnaround, so chip select is never driven by two owners and MISO is never enabled toward the wrong master. It owns `cs_flash`, `wp_flash` and `miso_ena` in place of the standalone set/reset flip-flops. It sits beside the address decoder and consumes the already-buffered and debounced bus signals.

---
 rtl/flash_spi_arbiter_pm.sv | 207 ++++++++++++++++++++
 tb/tb_flash_spi_arbiter_pm.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/flash_spi_arbiter_pm.sv
// flash_spi_arbiter_pm: shares the SPI configuration flash between the DSP
// (memory-mapped bus requests) and FPGA3 (req/gnt pins). Ownership changes
// always pass through a guarded turnaround so chip select and MISO are never
// driven toward two masters.
module flash_spi_arbiter_pm #(
   parameter logic [10:0] FLASH_REQ_ADDR = 11'h411,
   parameter logic [10:0] FLASH_CS_ADDR  = 11'h412,
   parameter logic [10:0] FLASH_WP_ADDR  = 11'h413,
   parameter int unsigned TURN_CYCLES    = 4,
   parameter int unsigned TIMEOUT_CYCLES = 32'h0000_FFFF,
   parameter int unsigned CNT_W          = 16
) (
   input  logic        clkDspIn,
   input  logic        dsp_reset,
   input  logic        we_deb,
   input  logic        re_deb,
   input  logic [10:0] ab_buf,
   input  logic        fpga_req,
   input  logic        fpga_cs_n,
   output logic        fpga_gnt,
   output logic        dsp_gnt,
   output logic        spi_sel,
   output logic        cs_flash,
   output logic        wp_flash,
   output logic        miso_ena,
   output logic        timeout_flag
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DSP_OWN  = 2'd1,
      FPGA_OWN = 2'd2,
      TURN     = 2'd3
   } state_t;

   // Turnaround counts down from TURN_LOAD to 0; timeout fires on the edge
   // where the idle-ownership counter would reach TIMEOUT_CYCLES.
   localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               we_prev_q, we_prev_d;
   logic               re_prev_q, re_prev_d;
   logic               dsp_pend_q, dsp_pend_d;
   logic               dsp_cs_q, dsp_cs_d;
   logic               wp_unlock_q, wp_unlock_d;
   logic               last_owner_q, last_owner_d;   // 0 = DSP, 1 = FPGA3
   logic               tmo_flag_q, tmo_flag_d;
   logic               dsp_gnt_q, dsp_gnt_d;
   logic               fpga_gnt_q, fpga_gnt_d;
   logic               spi_sel_q, spi_sel_d;
   logic               miso_ena_q, miso_ena_d;
   logic               wp_flash_q, wp_flash_d;
   logic               cs_reg_q, cs_reg_d;

   logic               we_fall, re_fall;
   logic               req_wr, req_rd, cs_wr, cs_rd, wp_wr, wp_rd, any_ev;
   logic               tmo, pend_eff, enter_dsp, enter_fpga, enter_turn;

   // Strobe falling-edge detection and address decode for single-cycle events.
   always_comb begin
      we_fall = we_prev_q & ~we_deb;
      re_fall = re_prev_q & ~re_deb;
      req_wr  = we_fall && (ab_buf == FLASH_REQ_ADDR);
      req_rd  = re_fall && (ab_buf == FLASH_REQ_ADDR);
      cs_wr   = we_fall && (ab_buf == FLASH_CS_ADDR);
      cs_rd   = re_fall && (ab_buf == FLASH_CS_ADDR);
      wp_wr   = we_fall && (ab_buf == FLASH_WP_ADDR);
      wp_rd   = re_fall && (ab_buf == FLASH_WP_ADDR);
      any_ev  = req_wr | req_rd | cs_wr | cs_rd | wp_wr | wp_rd;
   end

   // Next-state, bookkeeping registers and registered output values.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      we_prev_d    = we_deb;
      re_prev_d    = re_deb;
      dsp_pend_d   = dsp_pend_q;
      dsp_cs_d     = dsp_cs_q;
      wp_unlock_d  = wp_unlock_q;
      last_owner_d = last_owner_q;
      tmo_flag_d   = tmo_flag_q;

      tmo      = (state_q == DSP_OWN) && (cnt_q >= TMO_LAST);
      pend_eff = dsp_pend_q & ~req_rd;

      case (state_q)
         IDLE: begin
            if (pend_eff && fpga_req) begin
               state_d = last_owner_q ? DSP_OWN : FPGA_OWN;
            end else if (pend_eff) begin
               state_d = DSP_OWN;
            end else if (fpga_req) begin
               state_d = FPGA_OWN;
            end
         end
         DSP_OWN: begin
            if (req_rd || tmo) state_d = TURN;
         end
         FPGA_OWN: begin
            if (!fpga_req) state_d = TURN;
         end
         TURN: begin
            if (cnt_q == '0) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      enter_dsp  = (state_d == DSP_OWN)  && (state_q != DSP_OWN);
      enter_fpga = (state_d == FPGA_OWN) && (state_q != FPGA_OWN);
      enter_turn = (state_d == TURN)     && (state_q != TURN);

      if (enter_dsp)       last_owner_d = 1'b0;
      else if (enter_fpga) last_owner_d = 1'b1;

      // A grant consumes the pending DSP request.
      if (enter_dsp)   dsp_pend_d = 1'b0;
      else if (req_wr) dsp_pend_d = 1'b1;
      else if (req_rd) dsp_pend_d = 1'b0;

      // One counter serves both as turnaround timer and idle-ownership timer.
      if (enter_turn) begin
         cnt_d = TURN_LOAD;
      end else if (enter_dsp) begin
         cnt_d = '0;
      end else if (state_q == TURN) begin
         if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
      end else if (state_q == DSP_OWN) begin
         if (any_ev)              cnt_d = '0;
         else if (cnt_q != '1)    cnt_d = cnt_q + CNT_ONE;
      end

      // Chip select and write-protect requests only matter while the DSP owns.
      if (enter_turn) begin
         dsp_cs_d    = 1'b0;
         wp_unlock_d = 1'b0;
      end else if (state_q == DSP_OWN) begin
         if (cs_wr)      dsp_cs_d = 1'b1;
         else if (cs_rd) dsp_cs_d = 1'b0;
         if (wp_wr)      wp_unlock_d = 1'b1;
         else if (wp_rd) wp_unlock_d = 1'b0;
      end

      if (tmo)         tmo_flag_d = 1'b1;
      else if (req_wr) tmo_flag_d = 1'b0;

      dsp_gnt_d  = (state_d == DSP_OWN);
      fpga_gnt_d = (state_d == FPGA_OWN);
      miso_ena_d = dsp_gnt_d;
      wp_flash_d = dsp_gnt_d & wp_unlock_d;
      cs_reg_d   = ~(dsp_gnt_d & dsp_cs_d);
      if (state_d == DSP_OWN)       spi_sel_d = 1'b0;
      else if (state_d == FPGA_OWN) spi_sel_d = 1'b1;
      else                          spi_sel_d = spi_sel_q;
   end

   // State and output registers; reset drops every grant immediately.
   always_ff @(posedge clkDspIn or negedge dsp_reset) begin
      if (!dsp_reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         we_prev_q    <= 1'b0;
         re_prev_q    <= 1'b0;
         dsp_pend_q   <= 1'b0;
         dsp_cs_q     <= 1'b0;
         wp_unlock_q  <= 1'b0;
         last_owner_q <= 1'b0;
         tmo_flag_q   <= 1'b0;
         dsp_gnt_q    <= 1'b0;
         fpga_gnt_q   <= 1'b0;
         spi_sel_q    <= 1'b0;
         miso_ena_q   <= 1'b0;
         wp_flash_q   <= 1'b0;
         cs_reg_q     <= 1'b1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         we_prev_q    <= we_prev_d;
         re_prev_q    <= re_prev_d;
         dsp_pend_q   <= dsp_pend_d;
         dsp_cs_q     <= dsp_cs_d;
         wp_unlock_q  <= wp_unlock_d;
         last_owner_q <= last_owner_d;
         tmo_flag_q   <= tmo_flag_d;
         dsp_gnt_q    <= dsp_gnt_d;
         fpga_gnt_q   <= fpga_gnt_d;
         spi_sel_q    <= spi_sel_d;
         miso_ena_q   <= miso_ena_d;
         wp_flash_q   <= wp_flash_d;
         cs_reg_q     <= cs_reg_d;
      end
   end

   // FPGA3 drives its own chip select straight through, gated by the
   // registered state so it can never leak outside FPGA_OWN.
   assign cs_flash     = (state_q == FPGA_OWN) ? fpga_cs_n : cs_reg_q;
   assign dsp_gnt      = dsp_gnt_q;
   assign fpga_gnt     = fpga_gnt_q;
   assign spi_sel      = spi_sel_q;
   assign miso_ena     = miso_ena_q;
   assign wp_flash     = wp_flash_q;
   assign timeout_flag = tmo_flag_q;

endmodule

// File: tb/tb_flash_spi_arbiter_pm.sv
// tb_flash_spi_arbiter_pm: directed bench for the SPI flash arbiter.
module tb_flash_spi_arbiter_pm;

   localparam logic [10:0] REQ = 11'h411;
   localparam logic [10:0] CS  = 11'h412;
   localparam logic [10:0] WP  = 11'h413;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        we_deb, re_deb;
   logic [10:0] ab_buf;
   logic        fpga_req, fpga_cs_n;
   logic        fpga_gnt, dsp_gnt, spi_sel, cs_flash, wp_flash, miso_ena, timeout_flag;

   int total = 0;
   int bad   = 0;
   int n;

   always #5 clk = ~clk;

   flash_spi_arbiter_pm #(
      .FLASH_REQ_ADDR (REQ),
      .FLASH_CS_ADDR  (CS),
      .FLASH_WP_ADDR  (WP),
      .TURN_CYCLES    (4),
      .TIMEOUT_CYCLES (16),
      .CNT_W          (16)
   ) dut (
      .clkDspIn     (clk),
      .dsp_reset    (rst_n),
      .we_deb       (we_deb),
      .re_deb       (re_deb),
      .ab_buf       (ab_buf),
      .fpga_req     (fpga_req),
      .fpga_cs_n    (fpga_cs_n),
      .fpga_gnt     (fpga_gnt),
      .dsp_gnt      (dsp_gnt),
      .spi_sel      (spi_sel),
      .cs_flash     (cs_flash),
      .wp_flash     (wp_flash),
      .miso_ena     (miso_ena),
      .timeout_flag (timeout_flag)
   );

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_wr(input logic [10:0] a);
      ab_buf = a;
      we_deb = 1'b0;
      tick();
      we_deb = 1'b1;
   endtask

   task automatic bus_rd(input logic [10:0] a);
      ab_buf = a;
      re_deb = 1'b0;
      tick();
      re_deb = 1'b1;
   endtask

   task automatic wait_any_gnt(output int cnt);
      cnt = 0;
      do begin
         tick();
         cnt++;
      end while (!dsp_gnt && !fpga_gnt && cnt < 30);
   endtask

   initial begin
      rst_n = 1'b0; we_deb = 1'b1; re_deb = 1'b1; ab_buf = '0;
      fpga_req = 1'b0; fpga_cs_n = 1'b1;
      tick(); tick(); tick();
      check("rst_cs", cs_flash, 1);
      check("rst_wp", wp_flash, 0);
      check("rst_miso", miso_ena, 0);
      check("rst_sel", spi_sel, 0);
      check("rst_fgnt", fpga_gnt, 0);
      check("rst_dgnt", dsp_gnt, 0);
      check("rst_tmo", timeout_flag, 0);
      rst_n = 1'b1;
      tick();

      // DSP request, grant latency, chip select
      bus_wr(REQ);
      check("req_lat1", dsp_gnt, 0);
      tick();
      check("req_gnt", dsp_gnt, 1);
      check("req_miso", miso_ena, 1);
      check("req_cs_idle", cs_flash, 1);
      tick(); tick();
      check("req_cs_hold", cs_flash, 1);
      bus_wr(CS);
      check("cs_sel", cs_flash, 0);
      tick();

      // Release with flash selected, then FPGA3 after the turnaround
      bus_rd(REQ);
      check("rel_dgnt", dsp_gnt, 0);
      check("rel_cs", cs_flash, 1);
      check("rel_miso", miso_ena, 0);
      fpga_req = 1'b1;
      wait_any_gnt(n);
      check("turn_len_f", n, 5);
      check("f_gnt", fpga_gnt, 1);
      check("f_dgnt", dsp_gnt, 0);
      check("f_sel", spi_sel, 1);
      check("f_miso", miso_ena, 0);
      fpga_cs_n = 1'b0; #1;
      check("f_cs_lo", cs_flash, 0);
      fpga_cs_n = 1'b1; #1;
      check("f_cs_hi", cs_flash, 1);
      bus_wr(WP);
      check("f_wp", wp_flash, 0);
      tick();
      bus_wr(REQ);
      check("f_keep", fpga_gnt, 1);
      fpga_req = 1'b0;
      tick();
      check("ft_fgnt", fpga_gnt, 0);
      check("ft_sel_hold", spi_sel, 1);
      check("ft_cs", cs_flash, 1);
      wait_any_gnt(n);
      check("turn_len_d", n, 5);
      check("d_gnt", dsp_gnt, 1);
      check("d_cs_cleared", cs_flash, 1);
      check("d_wp", wp_flash, 0);
      check("d_sel", spi_sel, 0);
      bus_wr(WP);
      check("wp_unlock", wp_flash, 1);
      tick();
      bus_rd(REQ);
      check("wp_relock", wp_flash, 0);
      check("wp_rel_dgnt", dsp_gnt, 0);

      // Ties: FPGA3 wins first, then after a DSP ownership FPGA3 wins again
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      bus_wr(REQ);
      fpga_req = 1'b1;
      tick();
      check("tie1_f", fpga_gnt, 1);
      check("tie1_d", dsp_gnt, 0);
      fpga_req = 1'b0;
      wait_any_gnt(n);
      check("tie1_turn", n, 6);
      check("tie1_dnext", dsp_gnt, 1);
      bus_rd(REQ);
      bus_wr(REQ);
      fpga_req = 1'b1;
      wait_any_gnt(n);
      check("tie2_lat", n, 4);
      check("tie2_f", fpga_gnt, 1);
      check("tie2_d", dsp_gnt, 0);

      // Asynchronous reset while FPGA3 drives chip select low
      fpga_cs_n = 1'b0; #1;
      check("ar_cs_pre", cs_flash, 0);
      #2 rst_n = 1'b0;
      #1;
      check("ar_cs", cs_flash, 1);
      check("ar_fgnt", fpga_gnt, 0);
      check("ar_sel", spi_sel, 0);
      fpga_req = 1'b0; fpga_cs_n = 1'b1;
      tick();
      rst_n = 1'b1;
      tick();

      // Idle-ownership timeout
      check("to_flag0", timeout_flag, 0);
      bus_wr(REQ);
      tick();
      check("to_gnt", dsp_gnt, 1);
      n = 0;
      do begin
         tick();
         n++;
      end while (dsp_gnt && n < 40);
      check("to_len", n, 16);
      check("to_flag", timeout_flag, 1);
      check("to_miso", miso_ena, 0);
      bus_wr(REQ);
      check("to_clr", timeout_flag, 0);
      bus_rd(REQ);
      repeat (10) tick();
      check("pend_cancel_d", dsp_gnt, 0);
      check("pend_cancel_f", fpga_gnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
